fwd_source_pipe: RTL and testbench
==================================

# fwd_source_pipe

Producer side of the EX-stage forwarding path: holds the EX/MEM and MEM/WB result registers that drive the forwarding selector's MEM/WB register numbers, ALU results, load data and WB load flag, and drives the register-file write port from the WB stage. It also detects the hazards that forwarding cannot cover (load-use, memory wait) and raises a single pipeline stall. It sits between the ALU output and the register file, alongside the EX-stage forwarding selector.

## Interface
- REG_W, 7, register number width; number 0 means "no write" and is never forwarded
- DATA_W, 32, datapath width

- clk  in  1  pipeline clock
- rst_n  in  1  asynchronous active-low reset
- ex_wreg  in  REG_W  destination register of the instruction leaving EX (0 = none/bubble)
- ex_alu_result  in  DATA_W  ALU result of the instruction leaving EX
- ex_load  in  1  instruction leaving EX is a load
- ex_rs, ex_rt  in  REG_W  source registers of the instruction currently in EX
- flush  in  1  squash the instruction leaving EX (exception/redirect)
- mem_ready  in  1  data memory has returned load data this cycle
- mem_read_data  in  DATA_W  load data; valid when mem_ready
- mem_reg_num  out  REG_W  MEM-stage forwarding register number
- mem_alu_result  out  DATA_W  MEM-stage forwarding value
- wb_reg_num  out  REG_W  WB-stage forwarding register number
- wb_alu_result  out  DATA_W  WB-stage ALU value
- wb_read_data  out  DATA_W  WB-stage load data
- wb_load  out  1  WB instruction is a load
- stall  out  1  hold PC/IF/ID/EX this cycle
- rf_we  out  1  register-file write enable
- rf_waddr  out  REG_W  register-file write address
- rf_wdata  out  DATA_W  register-file write data

## Operation
- Two stage registers: MEM {wreg, alu_result, load}, WB {wreg, alu_result, read_data, load}.
- mem_wait = MEM.load & MEM.wreg!=0 & !mem_ready.
- load_use = MEM.load & MEM.wreg!=0 & (MEM.wreg==ex_rs | MEM.wreg==ex_rt).
- stall = mem_wait | load_use (combinational).
- Normal cycle (stall=0): MEM <= flush ? bubble : {ex_wreg, ex_alu_result, ex_load}; WB <= MEM plus read_data <= mem_read_data.
- mem_wait: MEM holds; WB <= bubble (wreg=0, load=0, data unchanged).
- load_use without mem_wait: WB <= MEM (load completes, data captured); MEM <= bubble; EX held upstream.
- flush is ignored while stall=1 (EX is held; upstream squashes its own EX register).
- mem_reg_num = MEM.load ? 0 : MEM.wreg — a load's ALU result is an address and must never be forwarded.
- mem_alu_result = MEM.alu_result; wb_* = WB fields directly.
- rf_we = WB.wreg!=0; rf_waddr = WB.wreg; rf_wdata = WB.load ? WB.read_data : WB.alu_result.
- Non-load in MEM ignores mem_ready.

## Timing
- Reset (rst_n=0, asynchronous): all stage fields 0; hence all outputs 0, stall=0, rf_we=0.
- EX result visible on mem_* the cycle after capture, on wb_*/rf_* one cycle later; writes commit at the following edge.
- Load-use: exactly one stall cycle when mem_ready is high on the first MEM cycle; consumer in EX then gets data via WB forwarding (wb_load=1).
- Memory wait of N cycles gives N stall cycles plus one load-use cycle if dependent; the load advances on the edge where mem_ready=1.
- Back-to-back writes to the same register: MEM value takes priority for forwarding; no special handling here.

## Structure
- Shared pipeline package: REG_W, DATA_W, REG_ZERO constant, packed struct types for MEM and WB stage records plus a BUBBLE constant.
- One sub-module natural: fwd_hazard_detect (combinational mem_wait/load_use/stall); stage registers stay in the top.

## Test plan
- Reset mid-stream: ex_wreg=5, result 0x1234 captured, assert rst_n=0 -> all outputs 0 immediately, rf_we=0.
- ALU chain: ex_wreg=3 result 0xAAAA -> cycle+1 mem_reg_num=3/mem_alu_result=0xAAAA, cycle+2 rf_we=1 waddr=3 wdata=0xAAAA.
- Load-use: load wreg=8 (addr 0x100), ex_rs=8, mem_ready=1, mem_read_data=0xBEEF -> mem_reg_num=0, stall=1 for one cycle, then wb_reg_num=8, wb_load=1, rf_wdata=0xBEEF.
- Memory wait: load wreg=4, mem_ready low 3 cycles -> stall=1 for 3 cycles, WB bubbles (rf_we=0), load retires on 4th edge.
- Flush: ex_wreg=6 with flush=1, stall=0 -> MEM bubble, no rf write of 6; same with stall=1 -> flush ignored, MEM unchanged.
- Zero register: ex_wreg=0 result 0xFFFF -> mem_reg_num=0, rf_we never asserted, load to r0 never stalls.

Source files
------------

// File: rtl/fwd_source_pipe_pkg.sv
// rtl/fwd_source_pipe_pkg.sv - shared widths and stage record types for the forwarding source pipe
package fwd_source_pipe_pkg;

  localparam int REG_W  = 7;
  localparam int DATA_W = 32;

  localparam logic [REG_W-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic [REG_W-1:0]  wreg;
    logic [DATA_W-1:0] alu_result;
    logic              load;
  } mem_stage_t;

  typedef struct packed {
    logic [REG_W-1:0]  wreg;
    logic [DATA_W-1:0] alu_result;
    logic [DATA_W-1:0] read_data;
    logic              load;
  } wb_stage_t;

  localparam mem_stage_t MEM_BUBBLE = '0;

endpackage

// File: rtl/fwd_source_pipe_hazard.sv
// rtl/fwd_source_pipe_hazard.sv - combinational detection of hazards forwarding cannot cover
module fwd_hazard_detect
  import fwd_source_pipe_pkg::*;
(
  input  logic [REG_W-1:0] mem_wreg,
  input  logic             mem_load,
  input  logic             mem_ready,
  input  logic [REG_W-1:0] ex_rs,
  input  logic [REG_W-1:0] ex_rt,
  output logic             mem_wait,
  output logic             load_use,
  output logic             stall
);

  logic live_load;

  // A load to r0 produces nothing anyone can consume, so it never stalls.
  assign live_load = mem_load && (mem_wreg != REG_ZERO);
  assign mem_wait  = live_load && !mem_ready;
  assign load_use  = live_load && ((mem_wreg == ex_rs) || (mem_wreg == ex_rt));
  assign stall     = mem_wait || load_use;

endmodule

// File: rtl/fwd_source_pipe.sv
// rtl/fwd_source_pipe.sv - EX/MEM and MEM/WB result registers, forwarding sources and RF write port
module fwd_source_pipe
  import fwd_source_pipe_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_W-1:0]  ex_wreg,
  input  logic [DATA_W-1:0] ex_alu_result,
  input  logic              ex_load,
  input  logic [REG_W-1:0]  ex_rs,
  input  logic [REG_W-1:0]  ex_rt,
  input  logic              flush,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_read_data,
  output logic [REG_W-1:0]  mem_reg_num,
  output logic [DATA_W-1:0] mem_alu_result,
  output logic [REG_W-1:0]  wb_reg_num,
  output logic [DATA_W-1:0] wb_alu_result,
  output logic [DATA_W-1:0] wb_read_data,
  output logic              wb_load,
  output logic              stall,
  output logic              rf_we,
  output logic [REG_W-1:0]  rf_waddr,
  output logic [DATA_W-1:0] rf_wdata
);

  mem_stage_t mem_q, mem_d;
  wb_stage_t  wb_q, wb_d;
  logic       mem_wait, load_use;

  fwd_hazard_detect u_hazard (
    .mem_wreg  (mem_q.wreg),
    .mem_load  (mem_q.load),
    .mem_ready (mem_ready),
    .ex_rs     (ex_rs),
    .ex_rt     (ex_rt),
    .mem_wait  (mem_wait),
    .load_use  (load_use),
    .stall     (stall)
  );

  always_comb begin
    mem_d = mem_q;
    wb_d  = wb_q;
    if (mem_wait) begin
      // Load still outstanding: hold it in MEM and retire nothing.
      wb_d.wreg = REG_ZERO;
      wb_d.load = 1'b0;
    end else begin
      wb_d = '{wreg: mem_q.wreg, alu_result: mem_q.alu_result,
               read_data: mem_read_data, load: mem_q.load};
      // EX is frozen upstream on load-use, so insert a bubble behind the load.
      if (load_use || flush)
        mem_d = MEM_BUBBLE;
      else
        mem_d = '{wreg: ex_wreg, alu_result: ex_alu_result, load: ex_load};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q <= '0;
      wb_q  <= '0;
    end else begin
      mem_q <= mem_d;
      wb_q  <= wb_d;
    end
  end

  // A load's ALU result is its address, never a forwardable value.
  assign mem_reg_num    = mem_q.load ? REG_ZERO : mem_q.wreg;
  assign mem_alu_result = mem_q.alu_result;
  assign wb_reg_num     = wb_q.wreg;
  assign wb_alu_result  = wb_q.alu_result;
  assign wb_read_data   = wb_q.read_data;
  assign wb_load        = wb_q.load;
  assign rf_we          = (wb_q.wreg != REG_ZERO);
  assign rf_waddr       = wb_q.wreg;
  assign rf_wdata       = wb_q.load ? wb_q.read_data : wb_q.alu_result;

endmodule

// File: tb/tb_fwd_source_pipe.sv
// tb/tb_fwd_source_pipe.sv - directed and randomized checks of fwd_source_pipe against a reference model
module tb_fwd_source_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [6:0]  ex_wreg = '0, ex_rs = '0, ex_rt = '0;
  logic [31:0] ex_alu_result = '0, mem_read_data = '0;
  logic        ex_load = 1'b0, flush = 1'b0, mem_ready = 1'b0;
  logic [6:0]  mem_reg_num, wb_reg_num, rf_waddr;
  logic [31:0] mem_alu_result, wb_alu_result, wb_read_data, rf_wdata;
  logic        wb_load, stall, rf_we;

  int tests = 0;
  int fails = 0;

  // reference state: the instruction sitting in each stage
  logic [6:0]  m_wreg, w_wreg, nm_wreg, nw_wreg;
  logic [31:0] m_res, w_res, w_rd, nm_res, nw_res, nw_rd;
  logic        m_ld, w_ld, nm_ld, nw_ld;

  fwd_source_pipe dut (
    .clk(clk), .rst_n(rst_n), .ex_wreg(ex_wreg), .ex_alu_result(ex_alu_result),
    .ex_load(ex_load), .ex_rs(ex_rs), .ex_rt(ex_rt), .flush(flush),
    .mem_ready(mem_ready), .mem_read_data(mem_read_data),
    .mem_reg_num(mem_reg_num), .mem_alu_result(mem_alu_result),
    .wb_reg_num(wb_reg_num), .wb_alu_result(wb_alu_result),
    .wb_read_data(wb_read_data), .wb_load(wb_load), .stall(stall),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_wreg = '0; m_res = '0; m_ld = 1'b0;
    w_wreg = '0; w_res = '0; w_rd = '0; w_ld = 1'b0;
  endtask

  // Called at a negedge: apply EX-side inputs, check every output, work out the next stage contents.
  task automatic drive(input logic [6:0] wreg, input logic [31:0] res, input logic ld,
                       input logic [6:0] rs, input logic [6:0] rt, input logic fl,
                       input logic rdy, input logic [31:0] rd);
    logic waiting, dep;
    ex_wreg = wreg; ex_alu_result = res; ex_load = ld; ex_rs = rs; ex_rt = rt;
    flush = fl; mem_ready = rdy; mem_read_data = rd;
    #1;
    waiting = m_ld && (m_wreg != 0) && !rdy;
    dep     = m_ld && (m_wreg != 0) && (m_wreg == rs || m_wreg == rt);
    check("stall", stall, waiting || dep);
    check("mem_reg_num", mem_reg_num, m_ld ? 7'd0 : m_wreg);
    check("mem_alu_result", mem_alu_result, m_res);
    check("wb_reg_num", wb_reg_num, w_wreg);
    check("wb_alu_result", wb_alu_result, w_res);
    check("wb_read_data", wb_read_data, w_rd);
    check("wb_load", wb_load, w_ld);
    check("rf_we", rf_we, w_wreg != 0);
    check("rf_waddr", rf_waddr, w_wreg);
    check("rf_wdata", rf_wdata, w_ld ? w_rd : w_res);
    if (waiting) begin
      nm_wreg = m_wreg; nm_res = m_res; nm_ld = m_ld;
      nw_wreg = 0; nw_res = w_res; nw_rd = w_rd; nw_ld = 0;
    end else begin
      nw_wreg = m_wreg; nw_res = m_res; nw_rd = rd; nw_ld = m_ld;
      if (dep || fl) begin
        nm_wreg = 0; nm_res = 0; nm_ld = 0;
      end else begin
        nm_wreg = wreg; nm_res = res; nm_ld = ld;
      end
    end
  endtask

  task automatic advance();
    @(posedge clk);
    m_wreg = nm_wreg; m_res = nm_res; m_ld = nm_ld;
    w_wreg = nw_wreg; w_res = nw_res; w_rd = nw_rd; w_ld = nw_ld;
    @(negedge clk);
    #1;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    advance();
  endtask

  initial begin
    model_reset();
    #1;
    check("reset_stall", stall, 0);
    check("reset_rf_we", rf_we, 0);
    check("reset_mem_reg", mem_reg_num, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // ALU chain
    drive(3, 32'hAAAA, 0, 0, 0, 0, 1, 0); advance();
    check("chain_mem_reg", mem_reg_num, 3);
    check("chain_mem_val", mem_alu_result, 32'hAAAA);
    idle();
    check("chain_rf_we", rf_we, 1);
    check("chain_waddr", rf_waddr, 3);
    check("chain_wdata", rf_wdata, 32'hAAAA);
    idle();

    // load-use with data ready on first MEM cycle
    drive(8, 32'h100, 1, 0, 0, 0, 1, 0); advance();
    check("lu_mem_reg", mem_reg_num, 0);
    drive(0, 0, 0, 8, 0, 0, 1, 32'hBEEF);
    check("lu_stall", stall, 1);
    advance();
    drive(0, 0, 0, 8, 0, 0, 1, 0);
    check("lu_stall_clear", stall, 0);
    check("lu_wb_reg", wb_reg_num, 8);
    check("lu_wb_load", wb_load, 1);
    check("lu_wdata", rf_wdata, 32'hBEEF);
    advance();
    idle();

    // memory wait of 3 cycles
    drive(4, 32'h200, 1, 0, 0, 0, 1, 0); advance();
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 1, 2, 0, 0, 0);
      check("mw_stall", stall, 1);
      advance();
      check("mw_rf_we", rf_we, 0);
    end
    drive(0, 0, 0, 1, 2, 0, 1, 32'hCAFE);
    check("mw_release", stall, 0);
    advance();
    check("mw_waddr", rf_waddr, 4);
    check("mw_wdata", rf_wdata, 32'hCAFE);
    idle(); idle();

    // flush without stall squashes, with stall it is ignored
    drive(6, 32'h66, 0, 0, 0, 1, 1, 0); advance();
    check("fl_mem_reg", mem_reg_num, 0);
    idle();
    check("fl_rf_we", rf_we, 0);
    drive(9, 32'h300, 1, 0, 0, 0, 1, 0); advance();
    drive(6, 32'h66, 0, 0, 0, 1, 0, 0);
    check("fls_stall", stall, 1);
    advance();
    check("fls_mem_held", mem_alu_result, 32'h300);
    idle(); idle(); idle();

    // register zero
    drive(0, 32'hFFFF, 0, 0, 0, 0, 1, 0); advance();
    check("z_mem_reg", mem_reg_num, 0);
    drive(0, 32'h400, 1, 0, 0, 0, 1, 0); advance();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    check("z_no_stall", stall, 0);
    check("z_rf_we", rf_we, 0);
    advance();

    // reset mid-stream
    drive(5, 32'h1234, 0, 0, 0, 0, 1, 0); advance();
    idle();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("mrst_rf_we", rf_we, 0);
    check("mrst_wb_reg", wb_reg_num, 0);
    check("mrst_mem_val", mem_alu_result, 0);
    check("mrst_wdata", rf_wdata, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;

    // randomized traffic over a small register space to provoke hazards
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 7), $urandom, $urandom_range(0, 2) == 0,
            $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7) == 0,
            $urandom_range(0, 3) != 0, $urandom);
      advance();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
